// File: rtl/nfc_apb_if.sv
// nfc_apb_if: APB register front-end for a NAND flash controller with TX/RX byte FIFOs.
// Optional feature: define NFC_IRQ_EN to enable CTRL bit1 irq_en and a registered IRQ = done & irq_en.
module nfc_apb_if #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        P_clk,
    input  logic        P_nrst,
    input  logic        P_sel,
    input  logic        P_enable,
    input  logic        P_write,
    input  logic [7:0]  P_addr,
    input  logic [31:0] P_wdata,
    output logic [31:0] P_rdata,
    output logic        P_ready,
    output logic        P_slverr,
    output logic [7:0]  C_Cmd,
    output logic [7:0]  C_Addr,
    output logic [7:0]  C_Length,
    output logic [7:0]  C_RdData,
    output logic        C_CmdVld,
    output logic        C_AddrVld,
    output logic        C_Start,
    input  logic [7:0]  C_Status,
    input  logic [7:0]  C_WrData,
    input  logic        C_TxPop,
    input  logic        C_RxPush,
    input  logic        C_Done,
    output logic        IRQ
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    logic acc, wr, rd;
    logic a_cmd, a_addr, a_len, a_ctrl, a_stat, a_tx, a_rx, a_bad;
    logic [7:0] cmd_q, addr_q, len_q;
    logic cmd_vld_q, addr_vld_q, start_q, busy_q, done_q, ovf_q;
    logic busy_d, done_d, ovf_d;
    logic start_req, start_ok;
    logic [7:0] tx_mem [FIFO_DEPTH];
    logic [7:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [AW:0] tx_cnt_q, rx_cnt_q;
    logic tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;
    logic [31:0] status, rdata_c;
    logic unused_wdata;

    assign acc    = P_sel & P_enable;
    assign wr     = acc & P_write;
    assign rd     = acc & ~P_write;
    assign a_cmd  = P_addr == 8'h00;
    assign a_addr = P_addr == 8'h04;
    assign a_len  = P_addr == 8'h08;
    assign a_ctrl = P_addr == 8'h0C;
    assign a_stat = P_addr == 8'h10;
    assign a_tx   = P_addr == 8'h14;
    assign a_rx   = P_addr == 8'h18;
    assign a_bad  = ~(a_cmd | a_addr | a_len | a_ctrl | a_stat | a_tx | a_rx);

    assign tx_full  = tx_cnt_q == FULL;
    assign tx_empty = tx_cnt_q == '0;
    assign rx_full  = rx_cnt_q == FULL;
    assign rx_empty = rx_cnt_q == '0;
    // A full TX FIFO rejects the push even if the flash side pops in the same cycle.
    assign tx_push  = wr & a_tx & ~tx_full;
    assign tx_pop   = C_TxPop & ~tx_empty;
    assign rx_push  = C_RxPush & ~rx_full;
    assign rx_pop   = rd & a_rx & ~rx_empty;

    // C_Done beats a coincident START so the controller never restarts on its own completion.
    assign start_req = wr & a_ctrl & P_wdata[0];
    assign start_ok  = start_req & ~busy_q & ~C_Done;
    assign busy_d    = C_Done ? 1'b0 : (start_ok ? 1'b1 : busy_q);
    assign done_d    = C_Done | (done_q & ~(wr & a_stat & P_wdata[5]));
    assign ovf_d     = (C_RxPush & rx_full) | (ovf_q & ~(wr & a_stat & P_wdata[6]));

    assign status  = {16'h0, C_Status, 1'b0, ovf_q, done_q, rx_empty, rx_full, tx_empty, tx_full, busy_q};
    assign rdata_c = a_len ? {24'h0, len_q} :
                     a_stat ? status :
                     (a_rx & ~rx_empty) ? {24'h0, rx_mem[rx_rp_q]} : 32'h0;

    assign P_rdata   = (P_nrst & rd) ? rdata_c : 32'h0;
    assign P_slverr  = P_nrst & acc & (a_bad | (start_req & (busy_q | C_Done)) |
                                       (wr & a_tx & tx_full) | (rd & a_rx & rx_empty));
    assign P_ready   = P_nrst;
    assign C_RdData  = (P_nrst & ~tx_empty) ? tx_mem[tx_rp_q] : 8'h0;
    assign C_Cmd     = cmd_q;
    assign C_Addr    = addr_q;
    assign C_Length  = len_q;
    assign C_CmdVld  = cmd_vld_q;
    assign C_AddrVld = addr_vld_q;
    assign C_Start   = start_q;
    assign unused_wdata = ^P_wdata[31:8];

    // FIFO storage needs no reset: occupancy counters define what is valid.
    always_ff @(posedge P_clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= P_wdata[7:0];
        if (rx_push) rx_mem[rx_wp_q] <= C_WrData;
    end

    // Register file, strobes, status flags and FIFO pointers.
    always_ff @(posedge P_clk or negedge P_nrst) begin
        if (!P_nrst) begin
            cmd_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cmd_vld_q  <= 1'b0;
            addr_vld_q <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_cnt_q   <= '0;
        end else begin
            if (wr & a_cmd) cmd_q <= P_wdata[7:0];
            if (wr & a_addr) addr_q <= P_wdata[7:0];
            if (wr & a_len) len_q <= P_wdata[7:0];
            cmd_vld_q  <= wr & a_cmd;
            addr_vld_q <= wr & a_addr;
            start_q    <= start_ok;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            tx_wp_q    <= tx_wp_q + AW'(tx_push);
            tx_rp_q    <= tx_rp_q + AW'(tx_pop);
            tx_cnt_q   <= tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
            rx_wp_q    <= rx_wp_q + AW'(rx_push);
            rx_rp_q    <= rx_rp_q + AW'(rx_pop);
            rx_cnt_q   <= rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        end
    end

`ifdef NFC_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;
    assign irq_en_d = irq_en_q | (wr & a_ctrl & P_wdata[1]);
    assign IRQ      = irq_q;

    // Sticky interrupt enable and registered interrupt output tracking next-state done.
    always_ff @(posedge P_clk or negedge P_nrst) begin
        if (!P_nrst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= done_d & irq_en_d;
        end
    end
`else
    assign IRQ = 1'b0;
`endif
endmodule

// File: tb/tb_nfc_apb_if.sv
// tb_nfc_apb_if: scoreboard bench for nfc_apb_if; IRQ expectations follow NFC_IRQ_EN.
module tb_nfc_apb_if;
    logic        P_clk = 1'b0, P_nrst = 1'b0;
    logic        P_sel = 1'b0, P_enable = 1'b0, P_write = 1'b0;
    logic [7:0]  P_addr = '0;
    logic [31:0] P_wdata = '0;
    logic [31:0] P_rdata;
    logic        P_ready, P_slverr;
    logic [7:0]  C_Cmd, C_Addr, C_Length, C_RdData;
    logic        C_CmdVld, C_AddrVld, C_Start, IRQ;
    logic [7:0]  C_Status = '0, C_WrData = '0;
    logic        C_TxPop = 1'b0, C_RxPush = 1'b0, C_Done = 1'b0;

`ifdef NFC_IRQ_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif

    typedef struct packed { logic [31:0] rd; logic err; logic chk; } apb_t;
    apb_t apbq[$];
    logic [7:0] cmdq[$], addrq[$], txq[$];
    bit startq[$];
    apb_t e;
    int checks = 0, errors = 0;

    nfc_apb_if #(.FIFO_DEPTH(8)) dut (
        .P_clk(P_clk), .P_nrst(P_nrst), .P_sel(P_sel), .P_enable(P_enable), .P_write(P_write),
        .P_addr(P_addr), .P_wdata(P_wdata), .P_rdata(P_rdata), .P_ready(P_ready), .P_slverr(P_slverr),
        .C_Cmd(C_Cmd), .C_Addr(C_Addr), .C_Length(C_Length), .C_RdData(C_RdData),
        .C_CmdVld(C_CmdVld), .C_AddrVld(C_AddrVld), .C_Start(C_Start), .C_Status(C_Status),
        .C_WrData(C_WrData), .C_TxPop(C_TxPop), .C_RxPush(C_RxPush), .C_Done(C_Done), .IRQ(IRQ)
    );

    always #5 P_clk = ~P_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT-presented event pops and checks its expectation.
    always @(negedge P_clk) begin
        if (P_nrst) begin
            if (P_sel && P_enable) begin
                if (apbq.size() == 0) chk("apb_unexpected", 1, 0);
                else begin
                    e = apbq.pop_front();
                    chk("apb_slverr", {31'h0, P_slverr}, {31'h0, e.err});
                    if (e.chk) chk("apb_rdata", P_rdata, e.rd);
                end
            end
            if (C_CmdVld) begin
                if (cmdq.size() == 0) chk("cmdvld_unexpected", 1, 0);
                else chk("c_cmd", {24'h0, C_Cmd}, {24'h0, cmdq.pop_front()});
            end
            if (C_AddrVld) begin
                if (addrq.size() == 0) chk("addrvld_unexpected", 1, 0);
                else chk("c_addr", {24'h0, C_Addr}, {24'h0, addrq.pop_front()});
            end
            if (C_Start) begin
                if (startq.size() == 0) chk("start_unexpected", 1, 0);
                else begin
                    void'(startq.pop_front());
                    chk("start_pulse", {31'h0, C_Start}, 32'h1);
                end
            end
            if (C_TxPop) begin
                if (txq.size() == 0) chk("txpop_unexpected", 1, 0);
                else chk("tx_head", {24'h0, C_RdData}, {24'h0, txq.pop_front()});
            end
        end
    end

    task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee,
                       input logic done_p = 1'b0, input logic pop_p = 1'b0);
        apbq.push_back('{rd: er, err: ee, chk: ~w});
        @(posedge P_clk); #1;
        P_sel = 1'b1; P_enable = 1'b0; P_write = w; P_addr = a; P_wdata = d;
        @(posedge P_clk); #1;
        P_enable = 1'b1; C_Done = done_p; C_TxPop = pop_p;
        @(posedge P_clk); #1;
        P_sel = 1'b0; P_enable = 1'b0; C_Done = 1'b0; C_TxPop = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic ee);
        apb(1'b1, a, d, 32'h0, ee);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] er, input logic ee);
        apb(1'b0, a, 32'h0, er, ee);
    endtask

    task automatic txpop(input logic [7:0] exp);
        txq.push_back(exp);
        @(posedge P_clk); #1 C_TxPop = 1'b1;
        @(posedge P_clk); #1 C_TxPop = 1'b0;
    endtask

    task automatic rxpush(input logic [7:0] d);
        @(posedge P_clk); #1 C_RxPush = 1'b1; C_WrData = d;
        @(posedge P_clk); #1 C_RxPush = 1'b0;
    endtask

    task automatic done_pulse();
        @(posedge P_clk); #1 C_Done = 1'b1;
        @(posedge P_clk); #1 C_Done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        P_sel = 1'b1; P_enable = 1'b1; P_addr = 8'h50;
        #12;
        chk("rst_slverr", {31'h0, P_slverr}, 32'h0);
        chk("rst_rdata", P_rdata, 32'h0);
        chk("rst_ready", {31'h0, P_ready}, 32'h0);
        chk("rst_outs", {C_Cmd, C_Addr, C_Length, C_RdData}, 32'h0);
        chk("rst_pulses", {28'h0, C_CmdVld, C_AddrVld, C_Start, IRQ}, 32'h0);
        P_sel = 1'b0; P_enable = 1'b0;
        @(posedge P_clk); #1 P_nrst = 1'b1;
        chk("ready_after_rst", {31'h0, P_ready}, 32'h1);
        rd(8'h10, 32'h14, 1'b0);
        C_Status = 8'h5A;
        rd(8'h10, 32'h5A14, 1'b0);
        C_Status = 8'h00;
        wr(8'h08, 32'h3C, 1'b0);
        rd(8'h08, 32'h3C, 1'b0);
        chk("c_length", {24'h0, C_Length}, 32'h3C);
        rd(8'h1C, 32'h0, 1'b1);
        wr(8'h40, 32'h1, 1'b1);
        // CMD then five ADDR bytes
        cmdq.push_back(8'h80);
        wr(8'h00, 32'h80, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            addrq.push_back(8'(i));
            wr(8'h04, i, 1'b0);
        end
        chk("c_cmd_hold", {24'h0, C_Cmd}, 32'h80);
        // TX fill to full, overflow, drain
        for (int i = 0; i < 9; i++) wr(8'h14, 32'h10 + i, i == 8);
        rd(8'h10, 32'h12, 1'b0);
        for (int i = 0; i < 8; i++) txpop(8'(8'h10 + i));
        rd(8'h10, 32'h14, 1'b0);
        chk("tx_empty_rddata", {24'h0, C_RdData}, 32'h0);
        txpop(8'h00);
        wr(8'h14, 32'h77, 1'b0);
        chk("tx_after_empty_pop", {24'h0, C_RdData}, 32'h77);
        txpop(8'h77);
        // simultaneous push and pop with one entry
        wr(8'h14, 32'h30, 1'b0);
        txq.push_back(8'h30);
        apb(1'b1, 8'h14, 32'h31, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("tx_pushpop_head", {24'h0, C_RdData}, 32'h31);
        rd(8'h10, 32'h10, 1'b0);
        txpop(8'h31);
        // push into full FIFO while popping is rejected
        for (int i = 0; i < 8; i++) wr(8'h14, 32'h20 + i, 1'b0);
        txq.push_back(8'h20);
        apb(1'b1, 8'h14, 32'h28, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 8; i++) txpop(8'(8'h20 + i));
        chk("tx_full_pop_drop", {24'h0, C_RdData}, 32'h0);
        rd(8'h10, 32'h14, 1'b0);
        // START / busy / done
        startq.push_back(1'b1);
        wr(8'h0C, 32'h1, 1'b0);
        rd(8'h10, 32'h15, 1'b0);
        wr(8'h0C, 32'h1, 1'b1);
        done_pulse();
        rd(8'h10, 32'h34, 1'b0);
        wr(8'h10, 32'h20, 1'b0);
        rd(8'h10, 32'h14, 1'b0);
        apb(1'b1, 8'h0C, 32'h1, 32'h0, 1'b1, 1'b1, 1'b0);
        rd(8'h10, 32'h34, 1'b0);
        wr(8'h10, 32'h20, 1'b0);
        // IRQ
        startq.push_back(1'b1);
        wr(8'h0C, 32'h3, 1'b0);
        done_pulse();
        chk("irq_set", {31'h0, IRQ}, {31'h0, IRQ_EXP});
        rd(8'h10, 32'h34, 1'b0);
        wr(8'h10, 32'h20, 1'b0);
        chk("irq_clr", {31'h0, IRQ}, 32'h0);
        // RX fill with overflow and drain
        for (int i = 0; i < 9; i++) rxpush(8'(8'hA0 + i));
        rd(8'h10, 32'h4C, 1'b0);
        for (int i = 0; i < 8; i++) rd(8'h18, 32'hA0 + i, 1'b0);
        rd(8'h18, 32'h0, 1'b1);
        rd(8'h10, 32'h54, 1'b0);
        wr(8'h10, 32'h40, 1'b0);
        rd(8'h10, 32'h14, 1'b0);
        // reset in the middle of an operation
        startq.push_back(1'b1);
        wr(8'h0C, 32'h3, 1'b0);
        done_pulse();
        startq.push_back(1'b1);
        wr(8'h0C, 32'h1, 1'b0);
        wr(8'h14, 32'h55, 1'b0);
        cmdq.push_back(8'h09);
        wr(8'h00, 32'h09, 1'b0);
        chk("pre_rst_irq", {31'h0, IRQ}, {31'h0, IRQ_EXP});
        @(posedge P_clk); #3 P_nrst = 1'b0;
        #1;
        chk("mid_rst_outs", {C_Cmd, C_Addr, C_Length, C_RdData}, 32'h0);
        chk("mid_rst_misc", {28'h0, IRQ, P_ready, C_Start, P_slverr}, 32'h0);
        repeat (2) @(posedge P_clk);
        #1 P_nrst = 1'b1;
        repeat (5) @(posedge P_clk);
        rd(8'h10, 32'h14, 1'b0);
        rd(8'h08, 32'h0, 1'b0);
        repeat (3) @(posedge P_clk);
        chk("apbq_drained", apbq.size(), 0);
        chk("cmdq_drained", cmdq.size(), 0);
        chk("addrq_drained", addrq.size(), 0);
        chk("startq_drained", startq.size(), 0);
        chk("txq_drained", txq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
